operand_scoreboard: RTL and testbench
=====================================

Name: operand_scoreboard

Overview:
- Issue-stage interlock sitting directly downstream of the decode tables.
- Consumes the per-instruction register-usage flags (d/s/t from/to GPR/FPR, from/to fcond) plus register indices, and tracks pending writes to GPR, FPR and the FP condition flag.
- Withholds issue on RAW or WAW hazards against in-flight producers.
- Releases registers on writeback from the execution/memory/FPU units.

Parameters:
- NUM_REG, 32, registers per file (GPR and FPR each)
- REG_W, 5, register index width (clog2 of NUM_REG)
- CNT_W, 7, width of outstanding-write counter (holds 0..2*NUM_REG+1)

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- issue_valid  in  1  decoded instruction present
- issue_ready  out  1  scoreboard accepts instruction this cycle
- flush  in  1  squash the presented instruction (branch mispredict); no issue this cycle
- rd / rs / rt  in  REG_W each  d, s, t register fields
- d_from_gpr, d_from_fpr, d_to_gpr, d_to_fpr, s_from_gpr, s_from_fpr, t_from_gpr, t_from_fpr, from_fcond, to_fcond  in  1 each  usage flags from decode
- wb_gpr_en  in  1  GPR writeback this cycle
- wb_gpr_addr  in  REG_W  GPR written
- wb_fpr_en  in  1  FPR writeback this cycle
- wb_fpr_addr  in  REG_W  FPR written
- wb_fcond_en  in  1  fcond writeback this cycle
- gpr_busy  out  NUM_REG  registered pending-write mask, GPR
- fpr_busy  out  NUM_REG  registered pending-write mask, FPR
- fcond_busy  out  1  registered pending write, fcond
- outstanding  out  CNT_W  count of set busy bits
- idle  out  1  outstanding==0
- sb_err  out  1  sticky protocol error

Behaviour:
- Reset (rstn=0 at posedge): gpr_busy=0, fpr_busy=0, fcond_busy=0, outstanding=0, sb_err=0. idle=1.
- Reset mid-operation discards all pending state; writebacks arriving in the reset cycle are ignored.
- Effective busy (combinational): busy bit AND NOT same-cycle writeback to that register. A producer writing back in cycle N lets a consumer issue in cycle N (zero-bubble release).
- GPR 0 is never busy:
  - its bit is never set;
  - reads of r0 never stall;
  - d_to_gpr with rd=0 sets nothing.
- Hazard (combinational from the inputs and effective busy):
  - RAW: s_from_gpr&busyG[rs] | s_from_fpr&busyF[rs] | t_from_gpr&busyG[rt] | t_from_fpr&busyF[rt] | d_from_gpr&busyG[rd] | d_from_fpr&busyF[rd] | from_fcond&busyC.
  - WAW: d_to_gpr&busyG[rd] | d_to_fpr&busyF[rd] | to_fcond&busyC.
- issue_ready = ~hazard & ~flush. fire = issue_valid & issue_ready.
- Next state at posedge (rstn=1):
  - A writeback clears its bit.
  - fire with a to_* flag sets the destination bit.
  - Set and clear on the same bit in one cycle: set wins (bit stays 1). This is reachable only via the zero-bubble release path.
- outstanding update: outstanding + (number of bits set by fire) − (number of bits actually cleared); a set-and-clear on the same bit contributes +1−1. The count stays equal to popcount of all busy masks at every cycle.
- sb_err set, and held until reset, on:
  - writeback to a register whose busy bit is 0 (including wb_gpr_addr=0);
  - wb_fcond_en while fcond_busy=0.
  - The bit state is unchanged by an erroneous writeback.
- A flush with issue_valid=1 produces no state change from the issue path; writebacks in the same cycle still apply.
- No latency beyond 1 cycle: the busy mask reflects a fire at the next edge.

Test Plan:
1. Reset, then fire add rd=3 (d_to_gpr, rs=1, rt=2) -> next cycle gpr_busy=32'h8, outstanding=1, idle=0. Then present sub rs=3 with no wb -> issue_ready=0. Then assert wb_gpr_en, addr=3 in the same cycle -> issue_ready=1. Following cycle gpr_busy=0.
2. fdiv fd=5 in flight. fclt fs=5, ft=6 (to_fcond) -> stalled (RAW). Then wb_fpr 5 -> issues, fcond_busy=1. Then bc1t (from_fcond) stalls until wb_fcond_en.
3. WAW: fire lw rd=7. Second lw rd=7 -> issue_ready=0. wb 7 in the same cycle as the second fire -> gpr_busy[7] remains 1, outstanding stays 1.
4. addi rd=0 fires -> gpr_busy unchanged (0), outstanding=0. Read of r0 never stalls even after an erroneous wb_gpr addr=0, which raises sb_err=1 and keeps it high.
5. flush=1 with a valid, hazard-free lui rd=4 and a concurrent wb_fpr 9 (fpr_busy[9]=1) -> issue_ready=0, gpr_busy[4]=0, fpr_busy[9] cleared, outstanding decrements by 1.
6. Fill 10 GPR and 10 FPR busy bits (outstanding=20), then pulse rstn=0 for one cycle alongside a writeback -> all masks 0, outstanding=0, sb_err=0, idle=1.

Source files
------------

// File: rtl/operand_scoreboard.sv
// Issue-stage operand scoreboard.
// Tracks pending writes to the GPR file, the FPR file and the FP condition
// flag. Holds back a decoded instruction while it has a RAW or WAW hazard
// against an in-flight producer, and releases registers on writeback.
// A writeback in the same cycle as a dependent issue releases it with no
// bubble.
module operand_scoreboard #(
  parameter int NUM_REG = 32,
  parameter int REG_W   = 5,
  parameter int CNT_W   = 7
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               issue_valid,
  output logic               issue_ready,
  input  logic               flush,
  input  logic [REG_W-1:0]   rd,
  input  logic [REG_W-1:0]   rs,
  input  logic [REG_W-1:0]   rt,
  input  logic               d_from_gpr,
  input  logic               d_from_fpr,
  input  logic               d_to_gpr,
  input  logic               d_to_fpr,
  input  logic               s_from_gpr,
  input  logic               s_from_fpr,
  input  logic               t_from_gpr,
  input  logic               t_from_fpr,
  input  logic               from_fcond,
  input  logic               to_fcond,
  input  logic               wb_gpr_en,
  input  logic [REG_W-1:0]   wb_gpr_addr,
  input  logic               wb_fpr_en,
  input  logic [REG_W-1:0]   wb_fpr_addr,
  input  logic               wb_fcond_en,
  output logic [NUM_REG-1:0] gpr_busy,
  output logic [NUM_REG-1:0] fpr_busy,
  output logic               fcond_busy,
  output logic [CNT_W-1:0]   outstanding,
  output logic               idle,
  output logic               sb_err
);

  localparam logic [NUM_REG-1:0] ONE_HOT_0 = NUM_REG'(1);

  // Registered state.
  logic [NUM_REG-1:0] r_gpr_busy;
  logic [NUM_REG-1:0] r_fpr_busy;
  logic               r_fcond_busy;
  logic [CNT_W-1:0]   r_outstanding;
  logic               r_sb_err;

  // Combinational decode of this cycle's writebacks and issue.
  logic [NUM_REG-1:0] w_wb_gpr_oh;
  logic [NUM_REG-1:0] w_wb_fpr_oh;
  logic [NUM_REG-1:0] w_eff_gpr;
  logic [NUM_REG-1:0] w_eff_fpr;
  logic               w_eff_fcond;
  logic               w_raw;
  logic               w_waw;
  logic               w_fire;
  logic [NUM_REG-1:0] w_set_gpr;
  logic [NUM_REG-1:0] w_set_fpr;
  logic               w_set_fcond;
  logic [NUM_REG-1:0] w_clr_gpr;
  logic [NUM_REG-1:0] w_clr_fpr;
  logic               w_clr_fcond;
  logic               w_err;
  logic [CNT_W-1:0]   w_n_set;
  logic [CNT_W-1:0]   w_n_clr;

  // Effective busy, hazard detection, and the set/clear masks for next state.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned; an unassigned path would infer a latch.
    w_wb_gpr_oh = '0;
    w_wb_fpr_oh = '0;
    if (wb_gpr_en) w_wb_gpr_oh = ONE_HOT_0 << wb_gpr_addr;
    if (wb_fpr_en) w_wb_fpr_oh = ONE_HOT_0 << wb_fpr_addr;

    // A same-cycle writeback hides the busy bit from the hazard check.
    w_eff_gpr   = r_gpr_busy & ~w_wb_gpr_oh;
    w_eff_fpr   = r_fpr_busy & ~w_wb_fpr_oh;
    w_eff_fcond = r_fcond_busy & ~wb_fcond_en;

    w_raw = (s_from_gpr & w_eff_gpr[rs]) | (s_from_fpr & w_eff_fpr[rs]) |
            (t_from_gpr & w_eff_gpr[rt]) | (t_from_fpr & w_eff_fpr[rt]) |
            (d_from_gpr & w_eff_gpr[rd]) | (d_from_fpr & w_eff_fpr[rd]) |
            (from_fcond & w_eff_fcond);
    w_waw = (d_to_gpr & w_eff_gpr[rd]) | (d_to_fpr & w_eff_fpr[rd]) |
            (to_fcond & w_eff_fcond);

    issue_ready = ~(w_raw | w_waw) & ~flush;
    w_fire      = issue_valid & issue_ready;

    // r0 is hardwired: a write to it never marks anything busy.
    w_set_gpr   = '0;
    w_set_fpr   = '0;
    if (w_fire && d_to_gpr && (rd != '0)) w_set_gpr = ONE_HOT_0 << rd;
    if (w_fire && d_to_fpr)               w_set_fpr = ONE_HOT_0 << rd;
    w_set_fcond = w_fire & to_fcond;

    // Only a writeback to a busy register clears anything; one to an idle
    // register is a protocol error and leaves the state alone.
    w_clr_gpr   = w_wb_gpr_oh & r_gpr_busy;
    w_clr_fpr   = w_wb_fpr_oh & r_fpr_busy;
    w_clr_fcond = wb_fcond_en & r_fcond_busy;

    w_err = (wb_gpr_en & ~r_gpr_busy[wb_gpr_addr]) |
            (wb_fpr_en & ~r_fpr_busy[wb_fpr_addr]) |
            (wb_fcond_en & ~r_fcond_busy);

    // At most one bit per resource is set or cleared per cycle.
    w_n_set = CNT_W'(w_set_gpr != '0) + CNT_W'(w_set_fpr != '0) + CNT_W'(w_set_fcond);
    w_n_clr = CNT_W'(w_clr_gpr != '0) + CNT_W'(w_clr_fpr != '0) + CNT_W'(w_clr_fcond);
  end

  // State update: clear on writeback, then set on fire so set wins on a tie.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rstn) begin
      r_gpr_busy    <= '0;
      r_fpr_busy    <= '0;
      r_fcond_busy  <= 1'b0;
      r_outstanding <= '0;
      r_sb_err      <= 1'b0;
    end else begin
      r_gpr_busy    <= (r_gpr_busy & ~w_clr_gpr) | w_set_gpr;
      r_fpr_busy    <= (r_fpr_busy & ~w_clr_fpr) | w_set_fpr;
      r_fcond_busy  <= (r_fcond_busy & ~w_clr_fcond) | w_set_fcond;
      r_outstanding <= r_outstanding + w_n_set - w_n_clr;
      r_sb_err      <= r_sb_err | w_err;
    end
  end

  assign gpr_busy    = r_gpr_busy;
  assign fpr_busy    = r_fpr_busy;
  assign fcond_busy  = r_fcond_busy;
  assign outstanding = r_outstanding;
  assign idle        = (r_outstanding == '0);
  assign sb_err      = r_sb_err;

endmodule

// File: tb/tb_operand_scoreboard.sv
// Directed bench for operand_scoreboard. The stimulus thread drives one cycle
// at a time and queues what the DUT should show in that cycle; a separate
// monitor pops each entry at the falling edge and compares.
module tb_operand_scoreboard;

  logic        clk = 1'b0;
  logic        rstn;
  logic        issue_valid, issue_ready, flush;
  logic [4:0]  rd, rs, rt;
  logic        d_from_gpr, d_from_fpr, d_to_gpr, d_to_fpr;
  logic        s_from_gpr, s_from_fpr, t_from_gpr, t_from_fpr;
  logic        from_fcond, to_fcond;
  logic        wb_gpr_en, wb_fpr_en, wb_fcond_en;
  logic [4:0]  wb_gpr_addr, wb_fpr_addr;
  logic [31:0] gpr_busy, fpr_busy;
  logic        fcond_busy, idle, sb_err;
  logic [6:0]  outstanding;

  // Usage-flag masks for the ins() helper.
  localparam logic [9:0] DFG = 10'h001, DFF = 10'h002, DTG = 10'h004, DTF = 10'h008;
  localparam logic [9:0] SFG = 10'h010, SFF = 10'h020, TFG = 10'h040, TFF = 10'h080;
  localparam logic [9:0] FFC = 10'h100, TFC = 10'h200;

  typedef struct {
    string       nm;
    bit          chk_rdy;
    logic        rdy;
    logic [31:0] g;
    logic [31:0] f;
    logic        c;
    logic [6:0]  o;
    logic        err;
  } exp_t;

  exp_t q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Hand-maintained expected register state for the current cycle.
  logic [31:0] e_g, e_f;
  logic        e_c, e_err;
  logic [6:0]  e_o;

  operand_scoreboard #(.NUM_REG(32), .REG_W(5), .CNT_W(7)) dut (
    .clk(clk), .rstn(rstn),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .flush(flush),
    .rd(rd), .rs(rs), .rt(rt),
    .d_from_gpr(d_from_gpr), .d_from_fpr(d_from_fpr),
    .d_to_gpr(d_to_gpr), .d_to_fpr(d_to_fpr),
    .s_from_gpr(s_from_gpr), .s_from_fpr(s_from_fpr),
    .t_from_gpr(t_from_gpr), .t_from_fpr(t_from_fpr),
    .from_fcond(from_fcond), .to_fcond(to_fcond),
    .wb_gpr_en(wb_gpr_en), .wb_gpr_addr(wb_gpr_addr),
    .wb_fpr_en(wb_fpr_en), .wb_fpr_addr(wb_fpr_addr),
    .wb_fcond_en(wb_fcond_en),
    .gpr_busy(gpr_busy), .fpr_busy(fpr_busy), .fcond_busy(fcond_busy),
    .outstanding(outstanding), .idle(idle), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    issue_valid = 0; flush = 0; rd = 0; rs = 0; rt = 0;
    {to_fcond, from_fcond, t_from_fpr, t_from_gpr, s_from_fpr, s_from_gpr,
     d_to_fpr, d_to_gpr, d_from_fpr, d_from_gpr} = '0;
    wb_gpr_en = 0; wb_gpr_addr = 0; wb_fpr_en = 0; wb_fpr_addr = 0; wb_fcond_en = 0;
  endtask

  // Advance to the next cycle and return all inputs to their idle values.
  task automatic nxt();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic ins(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t,
                     input logic [9:0] fl);
    issue_valid = 1; rd = d; rs = s; rt = t;
    {to_fcond, from_fcond, t_from_fpr, t_from_gpr, s_from_fpr, s_from_gpr,
     d_to_fpr, d_to_gpr, d_from_fpr, d_from_gpr} = fl;
  endtask

  // Queue the expected view of the DUT for this cycle.
  task automatic expect_now(input string nm, input bit chk_rdy, input logic rdy);
    exp_t e;
    e.nm = nm; e.chk_rdy = chk_rdy; e.rdy = rdy;
    e.g = e_g; e.f = e_f; e.c = e_c; e.o = e_o; e.err = e_err;
    q.push_back(e);
  endtask

  // Monitor: compares the DUT against each queued entry at the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk_rdy) check({e.nm, "/issue_ready"}, 64'(issue_ready), 64'(e.rdy));
        check({e.nm, "/gpr_busy"},    64'(gpr_busy),    64'(e.g));
        check({e.nm, "/fpr_busy"},    64'(fpr_busy),    64'(e.f));
        check({e.nm, "/fcond_busy"},  64'(fcond_busy),  64'(e.c));
        check({e.nm, "/outstanding"}, 64'(outstanding), 64'(e.o));
        check({e.nm, "/idle"},        64'(idle),        64'(e.o == 0));
        check({e.nm, "/sb_err"},      64'(sb_err),      64'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    rstn = 0;
    e_g = 0; e_f = 0; e_c = 0; e_o = 0; e_err = 0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1;
    expect_now("reset", 1, 1);

    // 1: add r3 <- r1,r2; dependent sub stalls until r3 writes back.
    nxt(); ins(3, 1, 2, SFG | TFG | DTG); expect_now("t1_add", 1, 1);
    nxt(); e_g = 32'h8; e_o = 1; expect_now("t1_busy", 0, 0);
    nxt(); ins(0, 3, 1, SFG | TFG | DTG); expect_now("t1_sub_stall", 1, 0);
    nxt(); ins(0, 3, 1, SFG | TFG | DTG); wb_gpr_en = 1; wb_gpr_addr = 3;
    expect_now("t1_sub_release", 1, 1);
    nxt(); e_g = 0; e_o = 0; expect_now("t1_cleared", 1, 1);

    // 2: fdiv f5; fclt f5,f6 stalls; bc1t stalls on fcond.
    nxt(); ins(5, 1, 2, SFF | TFF | DTF); expect_now("t2_fdiv", 1, 1);
    nxt(); e_f = 32'h20; e_o = 1; ins(0, 5, 6, SFF | TFF | TFC);
    expect_now("t2_fclt_stall", 1, 0);
    nxt(); ins(0, 5, 6, SFF | TFF | TFC); wb_fpr_en = 1; wb_fpr_addr = 5;
    expect_now("t2_fclt_release", 1, 1);
    nxt(); e_f = 0; e_c = 1; e_o = 1; ins(0, 0, 0, FFC);
    expect_now("t2_bc1t_stall", 1, 0);
    nxt(); ins(0, 0, 0, FFC); wb_fcond_en = 1; expect_now("t2_bc1t_release", 1, 1);
    nxt(); e_c = 0; e_o = 0; expect_now("t2_cleared", 1, 1);

    // 3: WAW on r7; release and re-set in the same cycle keeps the bit.
    nxt(); ins(7, 1, 0, SFG | DTG); expect_now("t3_lw1", 1, 1);
    nxt(); e_g = 32'h80; e_o = 1; ins(7, 2, 0, SFG | DTG); expect_now("t3_waw_stall", 1, 0);
    nxt(); ins(7, 2, 0, SFG | DTG); wb_gpr_en = 1; wb_gpr_addr = 7;
    expect_now("t3_waw_release", 1, 1);
    nxt(); expect_now("t3_set_wins", 1, 1);
    nxt(); wb_gpr_en = 1; wb_gpr_addr = 7; expect_now("t3_drain", 1, 1);
    nxt(); e_g = 0; e_o = 0; expect_now("t3_cleared", 1, 1);

    // 4: write to r0 sets nothing; wb to r0 is an error; r0 reads never stall.
    nxt(); ins(0, 1, 0, SFG | DTG); expect_now("t4_addi_r0", 1, 1);
    nxt(); ins(0, 0, 0, SFG | TFG | DFG); wb_gpr_en = 1; wb_gpr_addr = 0;
    expect_now("t4_wb_r0", 1, 1);
    nxt(); e_err = 1; ins(0, 0, 0, SFG | TFG | DFG); expect_now("t4_err_set", 1, 1);
    nxt(); expect_now("t4_err_sticky", 1, 1);

    // 5: flush suppresses issue while a concurrent writeback still applies.
    nxt(); ins(9, 1, 0, SFG | DTF); expect_now("t5_lwc1", 1, 1);
    nxt(); e_f = 32'h200; e_o = 1; ins(4, 0, 0, DTG); flush = 1;
    wb_fpr_en = 1; wb_fpr_addr = 9; expect_now("t5_flush", 1, 0);
    nxt(); e_f = 0; e_o = 0; expect_now("t5_after_flush", 1, 1);

    // 6: fill ten GPR and ten FPR busy bits, then reset alongside a writeback.
    for (int i = 1; i <= 10; i++) begin
      nxt(); ins(5'(i), 0, 0, DTG);
    end
    for (int i = 1; i <= 10; i++) begin
      nxt(); ins(5'(i), 0, 0, DTF);
    end
    nxt(); e_g = 32'h7FE; e_f = 32'h7FE; e_o = 20; expect_now("t6_full", 0, 0);
    nxt(); rstn = 0; wb_gpr_en = 1; wb_gpr_addr = 3; ins(12, 0, 0, DTG);
    expect_now("t6_in_reset", 0, 0);
    nxt(); rstn = 1; e_g = 0; e_f = 0; e_c = 0; e_o = 0; e_err = 0;
    expect_now("t6_after_reset", 1, 1);

    nxt();
    nxt();
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
